// File: rtl/lz4_pkg.sv
// Shared definitions for the LZ4 match FIFO reader: match-word field layout,
// reader FSM state type and output buffer depth.
package lz4_pkg;

    localparam int OFFSET_MSB = 31;
    localparam int OFFSET_LSB = 16;
    localparam int MLEN_MSB   = 15;
    localparam int MLEN_LSB   = 8;
    localparam int LLEN_MSB   = 7;
    localparam int LLEN_LSB   = 0;

    localparam int WORD_W     = 32;
    localparam int BUF_DEPTH  = 2;
    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    function automatic logic [OFFSET_MSB-OFFSET_LSB:0] get_offset(input logic [WORD_W-1:0] w);
        return w[OFFSET_MSB:OFFSET_LSB];
    endfunction

    function automatic logic [MLEN_MSB-MLEN_LSB:0] get_mlen(input logic [WORD_W-1:0] w);
        return w[MLEN_MSB:MLEN_LSB];
    endfunction

    function automatic logic [LLEN_MSB-LLEN_LSB:0] get_llen(input logic [WORD_W-1:0] w);
        return w[LLEN_MSB:LLEN_LSB];
    endfunction

endpackage

// File: rtl/match_skid_buf.sv
// Two-entry circular buffer holding popped match words; supports push and pop
// in the same cycle, including when full (the pop frees the slot being written).
module match_skid_buf
    import lz4_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [WORD_W-1:0] mem_q [BUF_DEPTH];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign pop_ok_s  = pop_i && (count_q != 2'd0);
    assign push_ok_s = push_i && ((count_q != BUF_FULL) || pop_ok_s);

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; a popped slot is zeroed so an empty buffer presents all-zero data.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (flush_i) begin
                    mem_q[i] <= '0;
                end else if (push_ok_s && (wr_ptr_q == i[0])) begin
                    mem_q[i] <= push_data_i;
                end else if (pop_ok_s && (rd_ptr_q == i[0])) begin
                    mem_q[i] <= '0;
                end else begin
                    mem_q[i] <= mem_q[i];
                end
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/match_fifo_reader.sv
// Pops match words from the match FIFO, buffers them and presents decoded
// sequences downstream with end-of-file marking. Optional MATCH_READER_STAT_EN
// adds a saturating count of delivered sequences on stat_words.
module match_fifo_reader
    import lz4_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic        start_compress,
    input  logic        fifo_empty,
    input  logic        fifo_file_end,
    output logic        fifo_rd_req,
    input  logic [31:0] fifo_odata,
    input  logic        fifo_odata_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_offset,
    output logic [7:0]  out_match_len,
    output logic [7:0]  out_lit_len,
    output logic        out_last,
    output logic        done,
    output logic        busy
`ifdef MATCH_READER_STAT_EN
    ,
    output logic [31:0] stat_words
`endif
);

    rd_state_e         state_q, state_d;
    logic              inflight_q;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [WORD_W-1:0] head_s;
    logic [1:0]        occ_s;
    logic              active_s;
    logic              start_ok_s;
    logic              holdback_s;
    logic              xfer_s;
    logic              last_xfer_s;
    logic [2:0]        pipe_sum_s;
    logic              room_s;

    assign active_s   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_ok_s = start_compress && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // A lone word with nothing behind it may still turn out to be the last one.
    assign holdback_s  = (occ_s == 2'd1) && !inflight_q && fifo_empty && !fifo_file_end;
    assign out_valid   = active_s && (occ_s != 2'd0) && !holdback_s;
    assign xfer_s      = out_valid && out_ready;
    assign out_last    = out_valid && fifo_file_end && (occ_s == 2'd1) && !inflight_q;
    assign last_xfer_s = xfer_s && out_last;

    // Credit the slot freed by this cycle's transfer so a steady stream runs at one word per cycle.
    assign pipe_sum_s  = {1'b0, occ_s} + {2'b00, inflight_q};
    assign room_s      = pipe_sum_s < (3'd2 + {2'b00, xfer_s});
    assign fifo_rd_req = active_s && !fifo_empty && room_s;

    assign out_offset    = get_offset(head_s);
    assign out_match_len = get_mlen(head_s);
    assign out_lit_len   = get_llen(head_s);
    assign done          = done_q;
    assign busy          = busy_q;

    match_skid_buf u_buf (
        .clk         (clk),
        .rstN        (rstN),
        .flush_i     (start_ok_s),
        .push_i      (fifo_odata_valid),
        .push_data_i (fifo_odata),
        .pop_i       (xfer_s),
        .head_o      (head_s),
        .count_o     (occ_s)
    );

    // FSM next-state and done/busy next values.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (fifo_file_end && last_xfer_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (fifo_file_end) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_xfer_s || (fifo_file_end && (occ_s == 2'd0) && !inflight_q)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // FSM, inflight tracking and pulse registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_req;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef MATCH_READER_STAT_EN
    logic [31:0] stat_q;

    // Saturating count of accepted sequences for the current file.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stat_q <= 32'd0;
        end else if (start_ok_s) begin
            stat_q <= 32'd0;
        end else if (xfer_s && (stat_q != 32'hFFFF_FFFF)) begin
            stat_q <= stat_q + 32'd1;
        end else begin
            stat_q <= stat_q;
        end
    end

    assign stat_words = stat_q;
`endif

endmodule

// File: tb/tb_match_fifo_reader.sv
// Scoreboard bench for match_fifo_reader: a behavioural match FIFO feeds the
// DUT, stimulus queues expected sequences, and a monitor checks each transfer.
module tb_match_fifo_reader;
    import lz4_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start_compress;
    logic        fifo_empty;
    logic        fifo_file_end;
    logic        fifo_rd_req;
    logic [31:0] fifo_odata;
    logic        fifo_odata_valid;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_offset;
    logic [7:0]  out_match_len;
    logic [7:0]  out_lit_len;
    logic        out_last;
    logic        done;
    logic        busy;
`ifdef MATCH_READER_STAT_EN
    logic [31:0] stat_words;
`endif

    typedef struct {
        logic [15:0] off;
        logic [7:0]  mlen;
        logic [7:0]  llen;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fq[$];
    bit          term;
    bit          pend;
    int          checks, failures;
    int          cyc;
    int          rd_cnt, xfer_cnt, done_cnt;
    int          first_rd_cyc, first_vld_cyc, last_xfer_cyc, done_cyc;

    match_fifo_reader dut (
        .clk              (clk),
        .rstN             (rstN),
        .start_compress   (start_compress),
        .fifo_empty       (fifo_empty),
        .fifo_file_end    (fifo_file_end),
        .fifo_rd_req      (fifo_rd_req),
        .fifo_odata       (fifo_odata),
        .fifo_odata_valid (fifo_odata_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_offset       (out_offset),
        .out_match_len    (out_match_len),
        .out_lit_len      (out_lit_len),
        .out_last         (out_last),
        .done             (done),
        .busy             (busy)
`ifdef MATCH_READER_STAT_EN
        ,
        .stat_words       (stat_words)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural match FIFO: a request seen before an edge returns data in the next cycle.
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstN) begin
                fifo_odata_valid = 1'b0;
                pend = 1'b0;
            end else if (pend && fq.size() > 0) begin
                fifo_odata = fq.pop_front();
                fifo_odata_valid = 1'b1;
            end else begin
                fifo_odata_valid = 1'b0;
            end
            fifo_empty    = (fq.size() == 0);
            fifo_file_end = term && (fq.size() == 0);
            #1;
            pend = fifo_rd_req && rstN;
            if (pend) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
        end
    end

    // Monitor: checks each transfer against the scoreboard and stall stability.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [15:0] h_off;
        logic [7:0]  h_ml, h_ll;
        logic        h_last;
        int          bocc;
        prev_stall = 1'b0;
        bocc = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rstN) begin
                prev_stall = 1'b0;
                bocc = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(out_valid && out_offset == h_off && out_match_len == h_ml &&
                          out_lit_len == h_ll && out_last == h_last)) begin
                        failures++;
                        $display("FAIL hold_stable got v=%0b off=%h ml=%h ll=%h last=%0b exp v=1 off=%h ml=%h ll=%h last=%0b",
                                 out_valid, out_offset, out_match_len, out_lit_len, out_last, h_off, h_ml, h_ll, h_last);
                    end
                end
                if (fifo_odata_valid) begin
                    checks++;
                    if (bocc >= 2 && !(out_valid && out_ready)) begin
                        failures++;
                        $display("FAIL buf_overflow got arrival with occupancy=%0d exp free entry", bocc);
                    end
                end
                if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (out_valid && out_ready) begin
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL xfer_unexpected got off=%h ml=%h ll=%h last=%0b exp no transfer",
                                 out_offset, out_match_len, out_lit_len, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_offset !== e.off || out_match_len !== e.mlen ||
                            out_lit_len !== e.llen || out_last !== e.last) begin
                            failures++;
                            $display("FAIL xfer got off=%h ml=%h ll=%h last=%0b exp off=%h ml=%h ll=%h last=%0b",
                                     out_offset, out_match_len, out_lit_len, out_last, e.off, e.mlen, e.llen, e.last);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                h_off  = out_offset;
                h_ml   = out_match_len;
                h_ll   = out_lit_len;
                h_last = out_last;
                bocc = bocc + (fifo_odata_valid ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w, input logic [15:0] off,
                             input logic [7:0] ml, input logic [7:0] ll, input logic last);
        exp_t e;
        e.off = off; e.mlen = ml; e.llen = ll; e.last = last;
        fq.push_back(w);
        exp_q.push_back(e);
    endtask

    task automatic start_file();
        start_compress = 1'b1;
        @(negedge clk);
        start_compress = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit chk_timing);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            @(negedge clk);
            #4;
            n++;
        end
        check("done_seen", 32'(done_cnt != d0), 32'd1);
        if (chk_timing) check("done_latency", 32'(done_cyc), 32'(last_xfer_cyc + 1));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got timeout exp completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int x0;
        rstN = 1'b0; start_compress = 1'b0; out_ready = 1'b0; term = 1'b0;
        fifo_empty = 1'b1; fifo_file_end = 1'b0; fifo_odata = 32'd0; fifo_odata_valid = 1'b0;
        first_rd_cyc = -1; first_vld_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;

        // Reset values
        tick(2);
        check("rst_rd_req", 32'(fifo_rd_req), 32'd0);
        check("rst_valid",  32'(out_valid),   32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_data",   {out_offset, out_match_len, out_lit_len}, 32'd0);
        rstN = 1'b1;
        tick(2);

        // Four-word file, streaming
        term = 1'b0;
        push_word(32'h1234_0504, 16'h1234, 8'h05, 8'h04, 1'b0);
        push_word(32'hABCD_FF01, 16'hABCD, 8'hFF, 8'h01, 1'b0);
        push_word(32'h0001_0000, 16'h0001, 8'h00, 8'h00, 1'b0);
        push_word(32'hFFFF_80FF, 16'hFFFF, 8'h80, 8'hFF, 1'b1);
        term = 1'b1;
        out_ready = 1'b1;
        first_rd_cyc = -1; first_vld_cyc = -1;
        start_file();
        check("busy_run", 32'(busy), 32'd1);
        wait_done(40, 1'b1);
        check("first_latency", 32'(first_vld_cyc - first_rd_cyc), 32'd2);
        @(negedge clk); #4;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);

        // Back-pressure for 10 cycles
        term = 1'b0;
        out_ready = 1'b0;
        push_word(32'h0010_0302, 16'h0010, 8'h03, 8'h02, 1'b0);
        push_word(32'h0020_0403, 16'h0020, 8'h04, 8'h03, 1'b0);
        push_word(32'h0030_0504, 16'h0030, 8'h05, 8'h04, 1'b0);
        push_word(32'h0040_0605, 16'h0040, 8'h06, 8'h05, 1'b0);
        push_word(32'h0050_0706, 16'h0050, 8'h07, 8'h06, 1'b1);
        term = 1'b1;
        rd_cnt = 0;
        x0 = xfer_cnt;
        start_file();
        tick(10);
        check("stall_pops", 32'(rd_cnt), 32'd2);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_no_xfer", 32'(xfer_cnt - x0), 32'd0);
        out_ready = 1'b1;
        wait_done(40, 1'b1);
        check("stall_xfers", 32'(xfer_cnt - x0), 32'd5);

        // Single word, terminal 20 cycles late
        tick(1);
        term = 1'b0;
        push_word(32'h7777_0A0B, 16'h7777, 8'h0A, 8'h0B, 1'b1);
        x0 = xfer_cnt;
        start_file();
        tick(20);
        check("held_no_xfer", 32'(xfer_cnt - x0), 32'd0);
        check("held_valid", 32'(out_valid), 32'd0);
        term = 1'b1;
        wait_done(20, 1'b1);

        // Empty file
        tick(1);
        term = 1'b1;
        x0 = xfer_cnt;
        start_file();
        wait_done(20, 1'b0);
        check("empty_no_xfer", 32'(xfer_cnt - x0), 32'd0);
        check("empty_state", 32'(dut.state_q), 32'(ST_DONE));
        check("empty_busy", 32'(busy), 32'd0);

        // Reset mid-stream with two words buffered
        tick(1);
        term = 1'b0;
        out_ready = 1'b0;
        fq.push_back(32'h1111_1111);
        fq.push_back(32'h2222_2222);
        fq.push_back(32'h3333_3333);
        fq.push_back(32'h4444_4444);
        start_file();
        tick(6);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rstN = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_rd_req", 32'(fifo_rd_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", {out_offset, out_match_len, out_lit_len}, 32'd0);
        fq.delete();
        exp_q.delete();
        tick(2);
        rstN = 1'b1;
        tick(1);
        push_word(32'h0BAD_0102, 16'h0BAD, 8'h01, 8'h02, 1'b0);
        push_word(32'h0C0D_0304, 16'h0C0D, 8'h03, 8'h04, 1'b1);
        term = 1'b1;
        out_ready = 1'b1;
        x0 = xfer_cnt;
        start_file();
        wait_done(30, 1'b1);
        check("restart_xfers", 32'(xfer_cnt - x0), 32'd2);

`ifdef MATCH_READER_STAT_EN
        // Sequence counter
        tick(1);
        term = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            push_word({16'(i), 8'(i), 8'(i)}, 16'(i), 8'(i), 8'(i), (i == 7));
        end
        term = 1'b1;
        start_file();
        wait_done(40, 1'b1);
        check("stat_count", stat_words, 32'd7);
        start_file();
        check("stat_clear", stat_words, 32'd0);
        wait_done(20, 1'b0);
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
